// File: rtl/adder_seq_pkg.sv
// Shared definitions for the byte-serial adder/subtractor controller.
//   state_t         : controller FSM encoding (also visible on the debug port)
//   NBYTES_DEFAULT  : default operand width in bytes
package adder_seq_pkg;

  localparam int NBYTES_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_cla_8b.sv
// 8-bit carry-lookahead adder, purely combinational.
//   i_a, i_b  : 8-bit addends
//   i_c_in    : carry-in
//   o_s       : 8-bit sum
//   o_c_out   : carry-out of bit 7
//   o_p, o_g  : group propagate / generate for cascading
module adder_cla_8b (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_c_in,
  output logic [7:0] o_s,
  output logic       o_c_out,
  output logic       o_p,
  output logic       o_g
);

  logic [7:0] p;
  logic [7:0] g;
  logic [8:0] c;
  logic       gen_v;
  logic       prop_v;

  assign p = i_a ^ i_b;
  assign g = i_a & i_b;

  // Each carry is the flattened lookahead sum of products
  // g[i] | p[i]g[i-1] | ... | p[i..0]c_in, not a ripple chain.
  always_comb begin
    c      = '0;
    gen_v  = 1'b0;
    prop_v = 1'b0;
    c[0]   = i_c_in;
    for (int i = 0; i < 8; i++) begin
      gen_v  = g[i];
      prop_v = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        gen_v  = gen_v | (prop_v & g[j]);
        prop_v = prop_v & p[j];
      end
      c[i+1] = gen_v | (prop_v & i_c_in);
    end
  end

  assign o_s     = p ^ c[7:0];
  assign o_c_out = c[8];
  assign o_p     = &p;
  // After the last loop iteration gen_v holds the carry-in-independent generate.
  assign o_g     = gen_v;

endmodule

// File: rtl/adder_seq_ctrl.sv
// Byte-serial add/subtract controller. One byte slice per cycle through a
// single shared 8-bit CLA, LSB first; result held until the consumer takes it.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_valid / o_ready     : request handshake (taken in IDLE only)
//   i_sub, i_c_in, i_a/b  : operation, carry-in (add only), operands
//   o_valid / i_ready     : result handshake (held in DONE)
//   o_s, o_c_out, o_ovf,
//   o_zero                : result and flags
//   o_dbg_state           : current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds its data stable while valid is high and
// ready is low. Request and result handshakes never complete on the same edge.
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_sub,
  input  logic                  i_c_in,
  input  logic [8*NBYTES-1:0]   i_a,
  input  logic [8*NBYTES-1:0]   i_b,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [8*NBYTES-1:0]   o_s,
  output logic                  o_c_out,
  output logic                  o_ovf,
  output logic                  o_zero,
  output state_t                o_dbg_state
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  state_t        state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;      // already inverted for subtract
  logic [W-1:0]  s_q;
  logic          carry_q;
  logic [IW-1:0] idx_q;

  logic [7:0]    a_byte;
  logic [7:0]    b_byte;
  logic [7:0]    sum_byte;
  logic          cla_c_out;
  logic          cla_p_unused;
  logic          cla_g_unused;

  // Byte offset formed by concatenation so it cannot overflow the index width.
  assign a_byte = a_q[{idx_q, 3'b000} +: 8];
  assign b_byte = b_q[{idx_q, 3'b000} +: 8];

  adder_cla_8b u_cla (
    .i_a     (a_byte),
    .i_b     (b_byte),
    .i_c_in  (carry_q),
    .o_s     (sum_byte),
    .o_c_out (cla_c_out),
    .o_p     (cla_p_unused),
    .o_g     (cla_g_unused)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            a_q     <= i_a;
            b_q     <= i_sub ? ~i_b : i_b;
            carry_q <= i_sub ? 1'b1 : i_c_in;
            idx_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          s_q[{idx_q, 3'b000} +: 8] <= sum_byte;
          carry_q <= cla_c_out;
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;    // index parks on the last byte
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready     = (state_q == IDLE);
  assign o_valid     = (state_q == DONE);
  assign o_s         = s_q;
  assign o_c_out     = carry_q;
  // Signed overflow: both addend MSBs agree but the result MSB does not.
  assign o_ovf       = (a_q[W-1] == b_q[W-1]) && (s_q[W-1] != a_q[W-1]);
  assign o_zero      = (s_q == '0);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
module tb_adder_seq_ctrl;
  import adder_seq_pkg::*;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk;
  logic         rst_n;
  logic         i_valid;
  logic         o_ready;
  logic         i_sub;
  logic         i_c_in;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_s;
  logic         o_c_out;
  logic         o_ovf;
  logic         o_zero;
  state_t       dbg_state;

  int n_checks;
  int n_fail;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  adder_seq_ctrl #(.NBYTES(NB)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_sub       (i_sub),
    .i_c_in      (i_c_in),
    .i_a         (i_a),
    .i_b         (i_b),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_s         (o_s),
    .o_c_out     (o_c_out),
    .o_ovf       (o_ovf),
    .o_zero      (o_zero),
    .o_dbg_state (dbg_state)
  );

  typedef struct {
    logic         sub;
    logic         c_in;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_s;
    logic         exp_c;
    logic         exp_ovf;
    logic         exp_zero;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: present a request at a negedge, return after the accepting edge
  task automatic send(input logic sub, input logic c_in, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    i_valid = 1'b1;
    i_sub   = sub;
    i_c_in  = c_in;
    i_a     = a;
    i_b     = b;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    i_a     = $urandom();
    i_b     = $urandom();
    i_sub   = 1'(($urandom_range(0, 1)));
  endtask

  // wait for o_valid with a cycle budget; returns cycles after the accept edge
  task automatic wait_valid(output int cycles);
    cycles = 1;
    while (!o_valid && cycles < 20) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    // loop entered one negedge after the accepting edge
    cycles = cycles - 1 + 1;
    if (!o_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_valid: o_valid never rose within 20 cycles");
    end
  endtask

  task automatic check_result(input string tag, input vec_t v);
    check({tag, ".s"},     64'(o_s),     64'(v.exp_s));
    check({tag, ".c_out"}, 64'(o_c_out), 64'(v.exp_c));
    check({tag, ".ovf"},   64'(o_ovf),   64'(v.exp_ovf));
    check({tag, ".zero"},  64'(o_zero),  64'(v.exp_zero));
    check({tag, ".ready"}, 64'(o_ready), 64'(0));
  endtask

  task automatic release_result(input string tag);
    i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_ready = 1'b0;
    check({tag, ".idle_ready"}, 64'(o_ready), 64'(1));
    check({tag, ".idle_valid"}, 64'(o_valid), 64'(0));
  endtask

  // full transaction including latency check
  task automatic run_vec(input string tag, input vec_t v);
    int cyc;
    send(v.sub, v.c_in, v.a, v.b);
    check({tag, ".calc_state"}, 64'(dbg_state), 64'(CALC));
    // at this negedge one edge (the accept) has passed; count edges until DONE
    cyc = 0;
    while (!o_valid && cyc < 20) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check({tag, ".latency"}, 64'(cyc), 64'(NB));
    check_result(tag, v);
    release_result(tag);
  endtask

  initial begin
    int cyc;
    logic [W-1:0] held_s;
    n_checks = 0;
    n_fail   = 0;

    //                sub   cin   a              b              s              c     ovf   zero
    vecs[0] = '{1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'h1234_5678, 32'h1111_1111, 32'h2345_678A, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 32'h0000_0010, 32'h0000_0003, 32'h0000_000D, 1'b1, 1'b0, 1'b0};

    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_sub   = 1'b0;
    i_c_in  = 1'b0;
    i_a     = '0;
    i_b     = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst.ready", 64'(o_ready), 64'(1));
    check("rst.valid", 64'(o_valid), 64'(0));
    check("rst.s",     64'(o_s),     64'(0));
    check("rst.c_out", 64'(o_c_out), 64'(0));
    check("rst.ovf",   64'(o_ovf),   64'(0));
    check("rst.state", 64'(dbg_state), 64'(IDLE));

    for (int i = 0; i < 9; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // stall in DONE: result held, requests ignored, then simultaneous handshakes
    send(1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001);
    cyc = 0;
    while (!o_valid && cyc < 20) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check("stall.latency", 64'(cyc), 64'(NB));
    held_s = 32'h0000_0100;
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'(k % 2);
      i_a     = $urandom();
      i_b     = $urandom();
      i_sub   = 1'(($urandom_range(0, 1)));
      @(posedge clk);
      @(negedge clk);
      check($sformatf("stall%0d.valid", k), 64'(o_valid), 64'(1));
      check($sformatf("stall%0d.s", k), 64'(o_s), 64'(held_s));
    end
    // i_valid and i_ready together in DONE: only the result handshake completes
    i_valid = 1'b1;
    i_ready = 1'b1;
    i_sub   = 1'b0;
    i_c_in  = 1'b0;
    i_a     = 32'h0000_0002;
    i_b     = 32'h0000_0003;
    @(posedge clk);
    @(negedge clk);
    i_ready = 1'b0;
    check("both.state", 64'(dbg_state), 64'(IDLE));
    check("both.ready", 64'(o_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    check("both.taken", 64'(dbg_state), 64'(CALC));
    cyc = 0;
    while (!o_valid && cyc < 20) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check("both.latency", 64'(cyc), 64'(NB));
    check("both.s", 64'(o_s), 64'(32'h0000_0005));
    release_result("both");

    // reset mid-calculation at index 2
    send(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("abort.state_before", 64'(dbg_state), 64'(CALC));
    rst_n = 1'b0;
    #1;
    check("abort.s",     64'(o_s),     64'(0));
    check("abort.c_out", 64'(o_c_out), 64'(0));
    check("abort.ovf",   64'(o_ovf),   64'(0));
    check("abort.valid", 64'(o_valid), 64'(0));
    check("abort.state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (o_valid) cyc++;
    end
    check("abort.no_valid", 64'(cyc), 64'(0));
    check("abort.ready", 64'(o_ready), 64'(1));
    run_vec("post_abort", vecs[4]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
